// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared FSM state type, shift width and address-width helper for the PE array sequencer
package pe_ctrl_pkg;
  localparam int BW_SHIFT = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_CLEAR,
    ST_WAIT,
    ST_WRITE
  } pe_ctrl_state_e;
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pe_loop_cnt.sv
// pe_loop_cnt: wrap-around loop index counter, 0..N-1, with synchronous clear
module pe_loop_cnt
  import pe_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = addr_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap = cnt_q == W'(N - 1);
  assign cnt  = cnt_q;
  always_comb cnt_d = clr ? '0 : inc ? (wrap ? '0 : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: output-stationary loop-nest sequencer (m, j, i) driving buffers and pe_array.
// Outputs are decoded from registered state so an asynchronous reset clears them at once.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int MAC_NUM = 10,
  parameter int IA_H    = 100,
  parameter int IA_W    = 150,
  parameter int OA_W    = 16,
  parameter int RES_LAT = 2,
  parameter int RD_LAT  = 1,
  localparam int J_N    = IA_H / MAC_NUM,
  localparam int ACT_AW = addr_w(J_N * IA_W),
  localparam int WET_AW = addr_w(IA_W * OA_W),
  localparam int OUT_AW = addr_w(OA_W * J_N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BW_SHIFT-1:0] cfg_shift,
  output logic                busy,
  output logic                done,
  output logic                act_rd_en,
  output logic [ACT_AW-1:0]   act_rd_addr,
  output logic                wet_rd_en,
  output logic [WET_AW-1:0]   wet_rd_addr,
  output logic                PE_mac_enable,
  output logic                PE_clear_acc,
  output logic [BW_SHIFT-1:0] PE_res_shift_num,
  output logic                out_wr_en,
  output logic [OUT_AW-1:0]   out_wr_addr
);
  localparam int IW = addr_w(IA_W);
  localparam int JW = addr_w(J_N);
  localparam int MW = addr_w(OA_W);
  pe_ctrl_state_e state_q, state_d;
  logic [BW_SHIFT-1:0] shift_q, shift_d;
  logic [7:0] dly_q, dly_d;
  logic done_q, done_d;
  logic [RD_LAT-1:0] mac_q, mac_d;
  logic [IW-1:0] i_cnt;
  logic [JW-1:0] j_cnt;
  logic [MW-1:0] m_cnt;
  logic i_wrap, j_wrap, m_wrap;
  logic go, rd_en, j_inc, m_inc, last;
  // start in the done cycle is deliberately dropped; it must be seen again in a plain IDLE cycle
  assign go    = (state_q == ST_IDLE) && start && !done_q;
  assign rd_en = state_q == ST_FETCH;
  assign j_inc = state_q == ST_WRITE;
  assign m_inc = j_inc && j_wrap;
  assign last  = m_inc && m_wrap;
  pe_loop_cnt #(.N(IA_W), .W(IW)) u_i (
    .clk(clk), .reset(reset), .clr(go), .inc(rd_en), .cnt(i_cnt), .wrap(i_wrap)
  );
  pe_loop_cnt #(.N(J_N), .W(JW)) u_j (
    .clk(clk), .reset(reset), .clr(go), .inc(j_inc), .cnt(j_cnt), .wrap(j_wrap)
  );
  pe_loop_cnt #(.N(OA_W), .W(MW)) u_m (
    .clk(clk), .reset(reset), .clr(go), .inc(m_inc), .cnt(m_cnt), .wrap(m_wrap)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = go ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_d = i_wrap ? ST_DRAIN : ST_FETCH;
      ST_DRAIN: state_d = (dly_q == 8'(RD_LAT - 1)) ? ST_CLEAR : ST_DRAIN;
      ST_CLEAR: state_d = (RES_LAT == 1) ? ST_WRITE : ST_WAIT;
      ST_WAIT:  state_d = (dly_q == 8'(RES_LAT - 2)) ? ST_WRITE : ST_WAIT;
      ST_WRITE: state_d = last ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    dly_d   = (state_d == state_q) ? dly_q + 8'd1 : '0;
    shift_d = go ? cfg_shift : shift_q;
    done_d  = last;
    mac_d   = RD_LAT'({mac_q, rd_en});
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      dly_q   <= '0;
      done_q  <= 1'b0;
      mac_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dly_q   <= dly_d;
      done_q  <= done_d;
      mac_q   <= mac_d;
    end
  assign busy             = state_q != ST_IDLE;
  assign done             = done_q;
  assign act_rd_en        = rd_en;
  assign wet_rd_en        = rd_en;
  assign act_rd_addr      = ACT_AW'(int'(j_cnt) * IA_W + int'(i_cnt));
  assign wet_rd_addr      = WET_AW'(int'(i_cnt) * OA_W + int'(m_cnt));
  assign out_wr_addr      = OUT_AW'(int'(m_cnt) * J_N + int'(j_cnt));
  assign PE_mac_enable    = mac_q[RD_LAT-1];
  assign PE_clear_acc     = state_q == ST_CLEAR;
  assign PE_res_shift_num = shift_q;
  assign out_wr_en        = state_q == ST_WRITE;
endmodule
